// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the RV32I core.
// Captures the decoded ID instruction for EX. It detects load-use hazards, stalls
// ID for one cycle and inserts a bubble, and it honours flush and downstream stall.
module id_ex_stage_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ALUOPW = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    input  logic [4:0]        id_rs1addr,
    input  logic [4:0]        id_rs2addr,
    input  logic [4:0]        id_rdaddr,
    input  logic [XLEN-1:0]   id_rs1data,
    input  logic [XLEN-1:0]   id_rs2data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_alusrc,
    input  logic [ALUOPW-1:0] id_aluop,

    input  logic              ex_stall,
    input  logic              flush,

    output logic              id_ex_valid,
    output logic [4:0]        id_ex_rs1addr,
    output logic [4:0]        id_ex_rs2addr,
    output logic [4:0]        id_ex_rdaddr,
    output logic [XLEN-1:0]   id_ex_rs1data,
    output logic [XLEN-1:0]   id_ex_rs2data,
    output logic [XLEN-1:0]   id_ex_imm,
    output logic [XLEN-1:0]   id_ex_pc,
    output logic              id_ex_regwrite,
    output logic              id_ex_memread,
    output logic              id_ex_memwrite,
    output logic              id_ex_alusrc,
    output logic [ALUOPW-1:0] id_ex_aluop,

    output logic              id_stall,
    output logic [15:0]       hazard_count
);

    // Register state (_q) and next state (_d)
    logic              valid_q,    valid_d;
    logic [4:0]        rs1addr_q,  rs1addr_d;
    logic [4:0]        rs2addr_q,  rs2addr_d;
    logic [4:0]        rdaddr_q,   rdaddr_d;
    logic [XLEN-1:0]   rs1data_q,  rs1data_d;
    logic [XLEN-1:0]   rs2data_q,  rs2data_d;
    logic [XLEN-1:0]   imm_q,      imm_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q,  memread_d;
    logic              memwrite_q, memwrite_d;
    logic              alusrc_q,   alusrc_d;
    logic [ALUOPW-1:0] aluop_q,    aluop_d;
    logic [15:0]       count_q,    count_d;

    logic              hazard;
    logic              count_sat;

    // Load-use detection: a valid load in EX writes a non-zero rd that the ID
    // instruction reads. x0 is never a real dependency.
    always_comb begin
        hazard = id_valid && valid_q && memread_q && (rdaddr_q != 5'd0) &&
                 ((rdaddr_q == id_rs1addr) || (rdaddr_q == id_rs2addr));
    end

    // A flush discards the ID instruction, so holding it upstream would be wrong.
    assign id_stall  = hazard & ~flush;
    assign count_sat = (count_q == 16'hFFFF);

    // Next-state selection. The priority is ex_stall, then flush, then hazard, then capture.
    always_comb begin
        valid_d    = valid_q;
        rs1addr_d  = rs1addr_q;
        rs2addr_d  = rs2addr_q;
        rdaddr_d   = rdaddr_q;
        rs1data_d  = rs1data_q;
        rs2data_d  = rs2data_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        alusrc_d   = alusrc_q;
        aluop_d    = aluop_q;
        count_d    = count_q;

        if (ex_stall) begin
            // Hold everything; the counter does not move either.
        end else if (flush || hazard) begin
            // Bubble: every field cleared so no stale control can leak downstream.
            valid_d    = 1'b0;
            rs1addr_d  = '0;
            rs2addr_d  = '0;
            rdaddr_d   = '0;
            rs1data_d  = '0;
            rs2data_d  = '0;
            imm_d      = '0;
            pc_d       = '0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            alusrc_d   = 1'b0;
            aluop_d    = '0;
            // Only hazard bubbles are counted. A flush that coincides with a hazard does not count.
            if (!flush && !count_sat) begin
                count_d = count_q + 16'd1;
            end
        end else begin
            valid_d    = id_valid;
            rs1addr_d  = id_rs1addr;
            rs2addr_d  = id_rs2addr;
            rdaddr_d   = id_rdaddr;
            rs1data_d  = id_rs1data;
            rs2data_d  = id_rs2data;
            imm_d      = id_imm;
            pc_d       = id_pc;
            // Side-effecting controls are qualified by valid.
            regwrite_d = id_valid & id_regwrite;
            memread_d  = id_valid & id_memread;
            memwrite_d = id_valid & id_memwrite;
            alusrc_d   = id_alusrc;
            aluop_d    = id_aluop;
        end
    end

    // State register with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs1addr_q  <= '0;
            rs2addr_q  <= '0;
            rdaddr_q   <= '0;
            rs1data_q  <= '0;
            rs2data_q  <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluop_q    <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            rs1addr_q  <= rs1addr_d;
            rs2addr_q  <= rs2addr_d;
            rdaddr_q   <= rdaddr_d;
            rs1data_q  <= rs1data_d;
            rs2data_q  <= rs2data_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            alusrc_q   <= alusrc_d;
            aluop_q    <= aluop_d;
            count_q    <= count_d;
        end
    end

    assign id_ex_valid    = valid_q;
    assign id_ex_rs1addr  = rs1addr_q;
    assign id_ex_rs2addr  = rs2addr_q;
    assign id_ex_rdaddr   = rdaddr_q;
    assign id_ex_rs1data  = rs1data_q;
    assign id_ex_rs2data  = rs2data_q;
    assign id_ex_imm      = imm_q;
    assign id_ex_pc       = pc_q;
    assign id_ex_regwrite = regwrite_q;
    assign id_ex_memread  = memread_q;
    assign id_ex_memwrite = memwrite_q;
    assign id_ex_alusrc   = alusrc_q;
    assign id_ex_aluop    = aluop_q;
    assign hazard_count   = count_q;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between the decode (ID) and execute (EX) stages of the pipelined RV32I core.
- Captures decoded operands, addresses, immediate, PC and control bits from ID, and presents them to EX and to the downstream EX/MEM register.
- Detects load-use hazards internally and stalls upstream for exactly one cycle while inserting a bubble.
- Supports a flush from branch/jump resolution.

Parameters:
- XLEN, 32, data/PC/immediate width
- ALUOPW, 4, width of ALU operation code

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- id_valid  input  1  ID stage holds a valid instruction
- id_rs1addr  input  5  source register 1 address
- id_rs2addr  input  5  source register 2 address
- id_rdaddr  input  5  destination register address
- id_rs1data  input  XLEN  register file read data 1
- id_rs2data  input  XLEN  register file read data 2
- id_imm  input  XLEN  sign-extended immediate
- id_pc  input  XLEN  instruction PC
- id_regwrite  input  1  instruction writes rd
- id_memread  input  1  instruction is a load
- id_memwrite  input  1  instruction is a store
- id_alusrc  input  1  ALU operand B selects immediate
- id_aluop  input  ALUOPW  ALU operation
- ex_stall  input  1  downstream cannot accept; hold all state
- flush  input  1  branch/jump taken; kill the ID-to-EX transfer
- id_ex_valid  output  1  EX holds a valid instruction
- id_ex_rs1addr, id_ex_rs2addr, id_ex_rdaddr  output  5 each  registered addresses
- id_ex_rs1data, id_ex_rs2data, id_ex_imm, id_ex_pc  output  XLEN each  registered data
- id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_alusrc  output  1 each  registered control
- id_ex_aluop  output  ALUOPW  registered ALU op
- id_stall  output  1  combinational; instructs PC and IF/ID registers to hold
- hazard_count  output  16  saturating count of load-use bubbles inserted

Behaviour:
- Reset (asynchronous, active-high): all registered outputs are 0, including id_ex_valid and hazard_count. Reset takes effect immediately, mid-operation included. The first capture happens on the first rising edge after rst deasserts.
- Load-use hazard (combinational): asserted when all of the following hold:
  - id_valid, id_ex_valid and id_ex_memread are 1;
  - id_ex_rdaddr != 0;
  - id_ex_rdaddr equals id_rs1addr or id_rs2addr.
  - id_stall = hazard & ~flush.
- Priority on each rising edge, highest first:
  1. ex_stall=1: hold every register unchanged; hazard_count is not incremented. id_stall is still driven per the hazard rule. Upstream must also hold because of ex_stall (handled externally).
  2. flush=1: load a bubble, i.e. id_ex_valid=0 and regwrite/memread/memwrite=0. Other fields are don't-care but must be loaded with 0.
  3. hazard=1: load a bubble as in rule 2 and increment hazard_count, saturating at 16'hFFFF. ID contents are retained externally via id_stall, so the same instruction is re-presented next cycle, by which point hazard is false.
  4. Otherwise: capture all id_* fields. id_ex_valid = id_valid. If id_valid=0, the control bits are forced to 0.
- Latency: 1 cycle from ID inputs to id_ex_* outputs.
- A bubble never asserts regwrite/memread/memwrite. Downstream stages gate on these bits plus valid.
- Loads targeting x0 never cause a stall.
- Flush and hazard in the same cycle: the flush wins, id_stall=0, and the count is not incremented.
- Back-to-back loads with the dependency on the second load stall once per dependent consumer.
- No arithmetic on data fields; hazard_count uses a 16-bit saturating increment.

Test Plan:
- Reset: assert rst mid-stream while id_ex_valid=1 and hazard_count=5 -> all outputs become 0 immediately, without waiting for a clock edge.
- Normal flow: id_valid=1, rs1=3, rs2=4, rd=5, imm=0x10, pc=0x100, aluop=2, regwrite=1 -> one cycle later id_ex_* equal the inputs and id_ex_valid=1, id_stall=0.
- Load-use: cycle N captures a load with rd=7. ID then presents an instruction with rs2=7 -> id_stall=1, the next edge yields id_ex_valid=0 and all control bits 0, hazard_count=1. The following edge captures the dependent instruction with id_stall=0.
- x0 load: load with rd=0, then a consumer with rs1=0 -> id_stall=0, no bubble, hazard_count unchanged.
- Flush versus hazard: hazard condition true and flush=1 in the same cycle -> id_stall=0, bubble loaded, hazard_count unchanged.
- Stall hold: ex_stall=1 for 3 cycles with changing id_* inputs -> all id_ex_* outputs are frozen at their prior values. On release, the current inputs are captured.
